// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone memory slave.
package wb_pkg;

  // Slave controller states.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Width of the wait-state down-counter; covers WAIT_CYCLES 0..15.
  localparam int WAIT_CNT_W = 4;

  // Byte replicated across a word to form the default clear value.
  localparam logic [7:0] INIT_BYTE = 8'h11;

endpackage

// File: rtl/wb_mem_array.sv
// Single-port storage with per-byte write enables and a registered read.
// Each byte lane is its own array so every lane maps onto a plain RAM.
module wb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int LANES = DATA_W / 8;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    // Read-before-write port: the lane writes when enabled and always reads.
    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        mem[addr] <= wdata[gi*8 +: 8];
      end
      q_reg <= mem[addr];
    end

    assign rdata[gi*8 +: 8] = q_reg;
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic memory slave: clears its storage after reset, then serves
// single reads/writes with optional wait states and an error for addresses
// beyond the implemented depth.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter int                DEPTH       = 256,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] INIT_VAL    = {(DATA_W/8){INIT_BYTE}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   adr_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [DATA_W-1:0]   dat_i,
  output logic [DATA_W-1:0]   dat_o,
  output logic                ack_o,
  output logic                err_o,
  output logic                busy_o
);

  localparam int LANES = DATA_W / 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                state_reg;
  logic [AW-1:0]         clr_addr_reg;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg;
  logic [ADDR_W-1:0]     adr_reg;
  logic                  we_reg;
  logic [LANES-1:0]      sel_reg;
  logic [DATA_W-1:0]     dat_reg;

  logic [AW-1:0]         mem_addr;
  logic                  mem_we;
  logic [LANES-1:0]      mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  // Memory port steering: the clear sweep, the live bus on the accept edge
  // (zero wait states) or the captured request on the last wait edge, so
  // both the write and the read sample happen on the edge entering RESP.
  always_comb begin
    mem_addr  = adr_reg[AW-1:0];
    mem_we    = 1'b0;
    mem_be    = sel_reg;
    mem_wdata = dat_reg;
    case (state_reg)
      ST_CLEAR: begin
        mem_addr  = clr_addr_reg;
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_wdata = INIT_VAL;
      end
      ST_IDLE: begin
        mem_addr  = adr_i[AW-1:0];
        mem_be    = sel_i;
        mem_wdata = dat_i;
        mem_we    = cyc_i && stb_i && (WAIT_CYCLES == 0) && we_i && in_range(adr_i);
      end
      ST_WAIT: begin
        mem_we = cyc_i && (wait_cnt_reg == WAIT_CNT_W'(1)) && we_reg && in_range(adr_reg);
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Controller: clear sweep, request capture, wait countdown and the
  // one-cycle registered termination.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
      wait_cnt_reg <= '0;
      ack_o        <= 1'b0;
      err_o        <= 1'b0;
      dat_o        <= '0;
      busy_o       <= 1'b1;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
      case (state_reg)
        ST_CLEAR: begin
          if (clr_addr_reg == AW'(DEPTH - 1)) begin
            state_reg <= ST_IDLE;
            busy_o    <= 1'b0;
          end else begin
            clr_addr_reg <= clr_addr_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (cyc_i && stb_i) begin
            adr_reg <= adr_i;
            we_reg  <= we_i;
            sel_reg <= sel_i;
            dat_reg <= dat_i;
            if (WAIT_CYCLES > 0) begin
              state_reg    <= ST_WAIT;
              wait_cnt_reg <= WAIT_CNT_W'(WAIT_CYCLES);
            end else begin
              state_reg <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (!cyc_i) begin
            state_reg <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
            if (wait_cnt_reg == WAIT_CNT_W'(1)) begin
              state_reg <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (!in_range(adr_reg)) begin
            err_o <= 1'b1;
          end else begin
            ack_o <= 1'b1;
            if (!we_reg) begin
              dat_o <= mem_rdata;
            end
          end
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg    <= ST_CLEAR;
          clr_addr_reg <= '0;
          busy_o       <= 1'b1;
        end
      endcase
    end
  end

  wb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (mem_we),
    .be    (mem_be),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/wb_mem_slave.md
WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits, a multiple of 8.
REQ-002 Parameter ADDR_W, default 8, word-address width.
REQ-003 Parameter DEPTH, default 256, number of implemented words, at most 2**ADDR_W.
REQ-004 Parameter WAIT_CYCLES, default 0, wait states inserted before ack, range 0..15.
REQ-005 Parameter INIT_VAL, default all 8'h11 bytes, word value written on reset clear.
REQ-006 Ports: clk, input, 1, clock; all logic on its rising edge.
REQ-007 Ports: rst, input, 1, reset, synchronous, active-high.
REQ-008 Ports: cyc_i, input, 1, bus cycle valid.
REQ-009 Ports: stb_i, input, 1, strobe for this slave.
REQ-010 Ports: we_i, input, 1, 1 = write, 0 = read.
REQ-011 Ports: adr_i, input, ADDR_W, word address.
REQ-012 Ports: sel_i, input, DATA_W/8, byte-lane enables.
REQ-013 Ports: dat_i, input, DATA_W, write data.
REQ-014 Ports: dat_o, output, DATA_W, read data, registered.
REQ-015 Ports: ack_o, output, 1, normal termination, registered.
REQ-016 Ports: err_o, output, 1, error termination, registered.
REQ-017 Ports: busy_o, output, 1, high while the post-reset clear runs.

Function
REQ-018 The FSM SHALL have four states: CLEAR, IDLE, WAIT, RESP.
REQ-019 CLEAR SHALL write INIT_VAL to one word per cycle, addresses 0..DEPTH-1 ascending, then go to IDLE; busy_o=1 throughout.
REQ-020 While busy_o=1, the slave SHALL ignore cyc_i and stb_i and SHALL issue no ack_o or err_o.
REQ-021 In IDLE, a request SHALL be accepted when cyc_i&stb_i=1; adr_i, we_i, sel_i and dat_i are captured on that edge.
REQ-022 On accept, the slave SHALL go to WAIT with a counter set to WAIT_CYCLES when WAIT_CYCLES>0, else directly to RESP.
REQ-023 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 0.
REQ-024 The first ack_o or err_o SHALL be high WAIT_CYCLES+1 cycles after the accept edge.
REQ-025 RESP SHALL last exactly one cycle with exactly one of ack_o or err_o high; the FSM then returns to IDLE.
REQ-026 A captured address >= DEPTH SHALL produce err_o, no memory update, and dat_o=0.
REQ-027 An in-range write SHALL update only the byte lanes whose sel_i bit is set, on the edge entering RESP; sel_i=0 still acks.
REQ-028 An in-range read SHALL load dat_o with mem[adr] on the edge entering RESP; sel_i does not mask read data.
REQ-029 dat_o SHALL be 0 in every cycle where ack_o=0.
REQ-030 If cyc_i falls while in WAIT, the slave SHALL abort to IDLE with no write, ack or err.
REQ-031 Back-to-back requests: the earliest next accept SHALL be the cycle after RESP, giving 1 idle cycle between terminations at WAIT_CYCLES=0.

Reset
REQ-032 rst=1 SHALL force CLEAR state, clear-address 0, ack_o=0, err_o=0, dat_o=0, busy_o=1 on the next edge.
REQ-033 rst asserted mid-transaction or mid-clear SHALL abort it and restart the clear from address 0.

Structure
REQ-034 Package wb_pkg SHALL hold the state enum, the WAIT counter width (4) and the default INIT byte.
REQ-035 Storage SHALL be a sub-module, wb_mem_array: a single-port, byte-write-enable, synchronous-read array; the FSM stays in wb_mem_slave.

Verification
REQ-036 Reset clear: rst 1 cycle at DEPTH=256 -> busy_o high 256 cycles; a read of 0x05 afterwards returns 0x11111111.
REQ-037 Write/read: WAIT_CYCLES=0, write 0xDEADBEEF to 0x10 with sel 0xF -> ack 1 cycle after accept; read of 0x10 returns 0xDEADBEEF.
REQ-038 Byte lanes: write 0xAABBCCDD to 0x20 with sel 0x5 over 0x11111111 -> read returns 0x11BB11DD.
REQ-039 Wait states: WAIT_CYCLES=3, read -> ack exactly 4 cycles after accept; cyc_i dropped after 2 cycles -> no ack and memory unchanged.
REQ-040 Error: DEPTH=200, access to 0xC8 -> err_o one cycle, ack_o=0, dat_o=0; word 0xC7 unaffected.
REQ-041 Request during clear: stb_i held high while busy_o=1 -> no termination until clear completes; accepted on the first IDLE cycle.
